// File: rtl/ex_pkg.sv
// Shared encodings for the execute-stage memory sequencer.
package ex_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_CONF  = 2'b11;

endpackage

// File: rtl/ex_wait_timer.sv
// Saturating wait counter; expired flags the last allowed wait cycle (count == TIMEOUT-1).
module ex_wait_timer
  import ex_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/ex_mem_seq.sv
// Sequences execute-stage loads/stores onto a single-outstanding memory port,
// stalling the pipeline while an access is in flight.
module ex_mem_seq
  import ex_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_i,
  input  logic        st_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  output logic        st_done_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [1:0]  dbg_state
);

  // Handshake: mem_req_o rises the cycle after acceptance and stays high with
  // we/addr/wdata frozen until the single-cycle mem_ack_i (or timeout); an ack
  // seen in any state other than BUSY carries no meaning and is dropped.

  state_t state, state_nxt;
  logic   req_any, conflict, misalign, accept, err_req;
  logic   ack_busy, timeout, tmr_en, tmr_expired;

  ex_wait_timer #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_BUSY;
      S_BUSY: begin
        // An ack on the final wait cycle still completes normally.
        if (mem_ack_i)        state_nxt = S_DONE;
        else if (tmr_expired) state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_any    = ld_i | st_i;
    conflict   = ld_i & st_i;
    misalign   = req_any & (addr_i[1:0] != 2'b00);
    err_req    = (state == S_IDLE) & (conflict | misalign);
    accept     = (state == S_IDLE) & req_any & ~conflict & ~misalign;
    ack_busy   = (state == S_BUSY) & mem_ack_i;
    tmr_en     = (state == S_BUSY) & ~mem_ack_i;
    timeout    = tmr_en & tmr_expired;
    mem_req_o  = (state == S_BUSY);
    stall_o    = (state == S_BUSY) | accept;
    ld_valid_o = (state == S_DONE) & ~mem_we_o;
    st_done_o  = (state == S_DONE) & mem_we_o;
    dbg_state  = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      ld_data_o   <= '0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
    end else begin
      err_o <= 1'b0;
      if (err_req) begin
        err_o      <= 1'b1;
        err_code_o <= conflict ? ERR_CONF : ERR_ALIGN;
      end
      if (timeout) begin
        err_o      <= 1'b1;
        err_code_o <= ERR_TMO;
      end
      if (accept) begin
        mem_addr_o  <= addr_i;
        mem_we_o    <= st_i;
        mem_wdata_o <= st_i ? st_data_i : '0;
      end
      if (ack_busy && !mem_we_o) ld_data_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_ex_mem_seq.sv
// Bench for ex_mem_seq: directed plan cases then random traffic, scoreboard-checked.
module tb_ex_mem_seq;

  localparam int TMO = 4;
  localparam int W   = 68;  // {cycle[31:0], kind[1:0], code[1:0], data[31:0]}
  localparam logic [1:0] K_LD = 2'd0, K_ST = 2'd1, K_ERR = 2'd2;

  logic        clk, rst;
  logic        ld_i, st_i, mem_ack_i;
  logic [31:0] addr_i, st_data_i, mem_rdata_i;
  logic        mem_req_o, mem_we_o, ld_valid_o, st_done_o, stall_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ld_data_o;
  logic [1:0]  err_code_o, dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [31:0]  last_ld  = '0;
  logic [1:0]   last_err = 2'b00;

  ex_mem_seq #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ld_i(ld_i), .st_i(st_i), .addr_i(addr_i),
    .st_data_i(st_data_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .ld_data_o(ld_data_o), .ld_valid_o(ld_valid_o),
    .st_done_o(st_done_o), .stall_o(stall_o), .err_o(err_o),
    .err_code_o(err_code_o), .dbg_state(dbg_state)
  );

  // Clock / cycle index
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    ld_i = 1'b0; st_i = 1'b0; addr_i = '0; st_data_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_ld_data", ld_data_o, 32'd0);
    check("rst_ld_valid", {31'd0, ld_valid_o}, 32'd0);
    check("rst_st_done", {31'd0, st_done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_err_code", {30'd0, err_code_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
  endtask

  // Driver: issues one request; d = wait cycles before ack (d >= TMO means no ack).
  // Reference model: conflict beats misalign beats access; an access with no ack
  // within TMO wait cycles times out, otherwise it reports d+2 cycles after issue.
  task automatic do_op(input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] data, input int d, input logic [31:0] rdata);
    int   c, busy_n;
    logic legal;
    @(posedge clk); #1;
    c     = cyc;
    legal = (ld || st) && !(ld && st) && (addr[1:0] == 2'b00);
    if (ld && st) begin
      last_err = 2'b11;
      exp_q.push_back({32'(c + 1), K_ERR, last_err, 32'd0});
    end else if ((ld || st) && addr[1:0] != 2'b00) begin
      last_err = 2'b01;
      exp_q.push_back({32'(c + 1), K_ERR, last_err, 32'd0});
    end else if (legal && d >= TMO) begin
      last_err = 2'b10;
      exp_q.push_back({32'(c + 1 + TMO), K_ERR, last_err, 32'd0});
    end else if (legal && st) begin
      exp_q.push_back({32'(c + 2 + d), K_ST, last_err, last_ld});
    end else if (legal) begin
      last_ld = rdata;
      exp_q.push_back({32'(c + 2 + d), K_LD, last_err, rdata});
    end
    ld_i = ld; st_i = st; addr_i = addr; st_data_i = data; mem_ack_i = 1'b0;
    #1 check("stall_issue", {31'd0, stall_o}, {31'd0, legal});
    if (legal) begin
      busy_n = (d < TMO) ? d + 1 : TMO;
      for (int i = 0; i < busy_n; i++) begin
        @(posedge clk); #1;
        ld_i = 1'($urandom_range(0, 1)); st_i = 1'($urandom_range(0, 1));
        addr_i = $urandom; st_data_i = $urandom;
        mem_ack_i   = (i == d);
        mem_rdata_i = (i == d) ? rdata : $urandom;
        #1;
        check("busy_req", {31'd0, mem_req_o}, 32'd1);
        check("busy_we", {31'd0, mem_we_o}, {31'd0, st});
        check("busy_addr", mem_addr_o, addr);
        check("busy_wdata", mem_wdata_o, st ? data : 32'd0);
        check("busy_stall", {31'd0, stall_o}, 32'd1);
      end
      @(posedge clk); #1;
      if (d < TMO) begin
        // DONE: requests presented here must be ignored
        ld_i = 1'($urandom_range(0, 1)); st_i = 1'($urandom_range(0, 1));
        addr_i = $urandom; mem_ack_i = 1'b0;
      end else begin
        // timeout cycle: a late ack must be ignored
        clear_inputs();
        mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      end
      #1;
      check("post_req", {31'd0, mem_req_o}, 32'd0);
      check("post_stall", {31'd0, stall_o}, 32'd0);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a result or error
  always @(negedge clk) begin
    logic [W-1:0] it;
    if (rst && (ld_valid_o || st_done_o || err_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {29'd0, ld_valid_o, st_done_o, err_o}, 32'd0);
      end else begin
        it = exp_q.pop_front();
        check("out_cycle", 32'(cyc), it[67:36]);
        check("out_ld_valid", {31'd0, ld_valid_o}, {31'd0, it[35:34] == K_LD});
        check("out_st_done", {31'd0, st_done_o}, {31'd0, it[35:34] == K_ST});
        check("out_err", {31'd0, err_o}, {31'd0, it[35:34] == K_ERR});
        check("out_err_code", {30'd0, err_code_o}, {30'd0, it[33:32]});
        if (it[35:34] != K_ERR) check("out_ld_data", ld_data_o, it[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] ra, rd, rr;
    int          r, dly;
    rst = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    #3 rst = 1'b1;

    // Directed plan cases
    do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 0, 32'h0);
    do_op(1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h0);
    do_op(1'b1, 1'b1, 32'h0000_0104, 32'h0, 0, 32'h0);
    do_op(1'b1, 1'b0, 32'h0000_0108, 32'h0, TMO, 32'h0);
    do_op(1'b0, 1'b1, 32'h0000_010C, 32'hCAFE_0001, 1, 32'h0);
    do_op(1'b1, 1'b0, 32'h0000_0110, 32'h0, TMO - 1, 32'hA5A5_5A5A);

    // Asynchronous reset in the middle of an access
    @(posedge clk); #1;
    ld_i = 1'b1; addr_i = 32'h0000_0300;
    @(posedge clk); #1;
    clear_inputs();
    #1 check("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
    #2 rst = 1'b0;
    #1 check("rst_drop_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_drop_stall", {31'd0, stall_o}, 32'd0);
    last_ld = '0; last_err = 2'b00;
    @(posedge clk); #1 check_reset_outputs();
    #3 rst = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    clear_inputs();
    do_op(1'b1, 1'b0, 32'h0000_0400, 32'h0, 2, 32'h0BAD_F00D);
    do_op(1'b0, 1'b1, 32'h0000_0404, 32'h7777_0000, 0, 32'h0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      ra = $urandom;
      rd = $urandom;
      rr = $urandom;
      ra[1:0] = (r == 9) ? 2'($urandom_range(1, 3)) : 2'b00;
      dly = $urandom_range(0, TMO + 1);
      case (r)
        0, 1, 2, 3: do_op(1'b1, 1'b0, ra, rd, dly, rr);
        8:          do_op(1'b1, 1'b1, ra, rd, dly, rr);
        9:          do_op(1'($urandom_range(0, 1)), 1'b1, ra, rd, dly, rr);
        default:    do_op(1'b0, 1'b1, ra, rd, dly, rr);
      endcase
    end

    repeat (4) @(posedge clk);
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_seq.md
Name: ex_mem_seq

Overview:
- Sequences load/store operations issued by the execute stage onto a single-outstanding memory port.
- Holds the pipeline stalled while an access is in flight.
- Returns load data with a one-cycle valid pulse.
- Reports misaligned, conflicting and timed-out accesses.
- Its stall output drives the execute stage's stall input.

Parameters:
TIMEOUT, 255, max cycles to wait for mem_ack_i before aborting (1..2^CNT_W-1)
CNT_W, 8, width of the wait counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active Low
ld_i  input  1  load requested this cycle (from execute control)
st_i  input  1  store requested this cycle
addr_i  input  32  effective address (rs + imm, computed upstream)
st_data_i  input  32  store data (rd value)
mem_req_o  output  1  memory request, held until ack
mem_we_o  output  1  1 = write, 0 = read; valid with mem_req_o
mem_addr_o  output  32  word address, stable while mem_req_o
mem_wdata_o  output  32  write data, stable while mem_req_o
mem_ack_i  input  1  memory completion strobe (one cycle)
mem_rdata_i  input  32  read data, valid with mem_ack_i
ld_data_o  output  32  captured load data
ld_valid_o  output  1  one-cycle pulse, ld_data_o valid
st_done_o  output  1  one-cycle pulse, store completed
stall_o  output  1  pipeline stall request
err_o  output  1  one-cycle error pulse
err_code_o  output  2  01 misaligned, 10 timeout, 11 ld&st conflict; held until next error

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ld_data_o, ld_valid_o, st_done_o, err_o, err_code_o.
  - Counter 0.
  - Reset mid-access drops mem_req_o immediately. Any later mem_ack_i is ignored.
- States: IDLE, BUSY, DONE.
- IDLE, evaluated in priority order:
  - ld_i & st_i: err_o=1 next cycle, err_code_o=11, no access, stay IDLE.
  - (ld_i|st_i) with addr_i[1:0]!=0: err_o=1 next cycle, err_code_o=01, no access, stay IDLE.
  - Otherwise ld_i|st_i: register mem_addr_o=addr_i, mem_we_o=st_i, mem_wdata_o=st_data_i (0 for loads). Set mem_req_o=1, counter=0, go to BUSY.
- BUSY:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held constant. ld_i/st_i/addr_i are ignored.
  - mem_ack_i=1: mem_req_o=0 next cycle, go to DONE.
    - Load: ld_data_o <= mem_rdata_i.
    - Store: ld_data_o keeps its previous value.
  - mem_ack_i=0: counter increments. When counter==TIMEOUT-1 with no ack, the next cycle has mem_req_o=0, err_o=1, err_code_o=10, and the block returns to IDLE.
  - Ack arriving in the same cycle as the final count wins: it is a normal completion, not a timeout.
- DONE (exactly 1 cycle):
  - ld_valid_o=1 for a load, st_done_o=1 for a store.
  - Go to IDLE. New requests are not accepted in DONE.
- mem_ack_i outside BUSY is ignored (no state change, no data capture).
- stall_o (combinational):
  - 1 when state==BUSY.
  - 1 when state==IDLE and a legal ld_i|st_i is accepted this cycle.
  - 0 in DONE, and 0 for rejected (error) requests.
  - The instruction is therefore held from its issue cycle through the ack cycle and released in the DONE cycle.
- Latency:
  - Request issued at cycle 0 → mem_req_o=1 at cycle 1.
  - Ack at cycle k (k≥1) → ld_valid_o/st_done_o at k+1.
  - Minimum total is 2 cycles (ack at cycle 1 → result at cycle 2).
- Counter saturates and never wraps. TIMEOUT=1 means a single wait cycle is allowed.
- err_o and ld_valid_o/st_done_o are never asserted together.

Decomposition:
- Shared package ex_pkg holds:
  - State encoding localparams S_IDLE, S_BUSY, S_DONE.
  - Error codes ERR_NONE=2'b00, ERR_ALIGN=2'b01, ERR_TMO=2'b10, ERR_CONF=2'b11.
- One sub-module, ex_wait_timer: a parameterised saturating counter with clear/enable inputs and an expired flag (CNT_W, TIMEOUT).
- All other logic stays in ex_mem_seq.

Test Plan:
- Load, ack after 3 cycles:
  - Stimulus: ld_i=1, addr_i=0x0000_0100 at cycle 0; mem_ack_i at cycle 4 with rdata=0xDEAD_BEEF.
  - Response: mem_req_o=1 for cycles 1-4 with mem_we_o=0 and addr 0x100; stall_o=1 for cycles 0-4; ld_valid_o=1 and ld_data_o=0xDEAD_BEEF at cycle 5.
- Store, immediate ack:
  - Stimulus: st_i=1, addr=0x200, data=0x1234_5678; ack at cycle 1.
  - Response: mem_we_o=1 and wdata=0x1234_5678 at cycle 1; st_done_o=1 at cycle 2; ld_data_o unchanged.
- Misalign and conflict:
  - Stimulus: ld_i=1 with addr=0x102.
  - Response: no mem_req_o, stall_o=0, err_o pulse with code 01.
  - Stimulus: ld_i=st_i=1.
  - Response: err_o pulse with code 11.
- Timeout:
  - Stimulus: TIMEOUT=4, load issued, no ack.
  - Response: mem_req_o high for 4 cycles, then err_o with code 10; a stray ack afterwards is ignored (no ld_valid_o).
- Ack on final count:
  - Stimulus: TIMEOUT=4, ack in the 4th wait cycle.
  - Response: normal ld_valid_o, no err_o.
- Reset during BUSY:
  - Stimulus: rst=0 asynchronously at mid-cycle.
  - Response: mem_req_o and stall_o drop immediately; after release, a new load completes normally.
